// File: rtl/atm_credential_entry.sv
// ATM credential entry: keypad-driven account/PIN capture, table lookup and
// wrong-PIN lockout, built as a single registered FSM.
module atm_credential_entry #(
   parameter int DIGITS    = 4,
   parameter int NUM_ACCTS = 3,
   parameter int MAX_TRIES = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          key_valid,
   input  logic [7:0]                    ascii_code,
   input  logic [NUM_ACCTS*4*DIGITS-1:0] acct_table,
   input  logic [NUM_ACCTS*4*DIGITS-1:0] pin_table,
   output logic [4*DIGITS-1:0]           acct,
   output logic [4*DIGITS-1:0]           pswd,
   output logic [3:0]                    acct_idx,
   output logic [3:0]                    status_code,
   output logic                          status_valid,
   output logic                          busy,
   output logic                          locked
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [2:0]    TRY_LIM = 3'(MAX_TRIES);

   localparam logic [3:0] ST_ACC_FOUND     = 4'b0001;
   localparam logic [3:0] ST_ACC_NOT_FOUND = 4'b0010;
   localparam logic [3:0] ST_PIN_CORRECT   = 4'b0011;
   localparam logic [3:0] ST_PIN_INCORRECT = 4'b0100;
   localparam logic [3:0] ST_EXIT          = 4'b0111;
   localparam logic [3:0] ST_INPUT_DONE    = 4'b1000;

   typedef enum logic [2:0] {
      IDLE, ACCT_ENTRY, ACCT_CHECK, PIN_ENTRY, PIN_CHECK, DONE, LOCKED
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    tries;
   logic [2:0]    tries_nx;

   logic is_digit, is_bs, is_enter, is_quit;
   assign is_digit = key_valid && (ascii_code >= 8'h30) && (ascii_code <= 8'h39);
   assign is_bs    = key_valid && (ascii_code == 8'h08);
   assign is_enter = key_valid && (ascii_code == 8'h0D);
   assign is_quit  = key_valid && (ascii_code == 8'h71);
   assign tries_nx = tries + 3'd1;

   // The buffer being edited depends on which entry state is active.
   logic [BW-1:0] ent_buf, ent_shl, ent_shr;
   always_comb begin
      ent_buf = (state == PIN_ENTRY) ? pswd : acct;
      ent_shl = {ent_buf[BW-5:0], ascii_code[3:0]};
      ent_shr = ent_buf >> 4;
   end

   // Descending scan so the lowest matching index wins.
   logic          acct_hit;
   logic [3:0]    hit_idx;
   logic [BW-1:0] pin_sel;
   always_comb begin
      acct_hit = 1'b0;
      hit_idx  = '0;
      pin_sel  = '0;
      for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
         if (acct == acct_table[i*BW +: BW]) begin
            acct_hit = 1'b1;
            hit_idx  = 4'(i);
         end
      end
      for (int i = 0; i < NUM_ACCTS; i++) begin
         if (acct_idx == 4'(i)) pin_sel = pin_table[i*BW +: BW];
      end
   end

   assign busy   = (state != IDLE);
   assign locked = (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         tries        <= '0;
         acct         <= '0;
         pswd         <= '0;
         acct_idx     <= '0;
         status_code  <= '0;
         status_valid <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCT_ENTRY;
                  cnt      <= '0;
                  tries    <= '0;
                  acct     <= '0;
                  pswd     <= '0;
                  acct_idx <= '0;
               end
            end
            ACCT_ENTRY, PIN_ENTRY: begin
               if (is_quit) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  tries        <= '0;
                  acct         <= '0;
                  pswd         <= '0;
                  acct_idx     <= '0;
                  status_code  <= ST_EXIT;
                  status_valid <= 1'b1;
               end else if (is_digit && (cnt != FULL)) begin
                  if (state == ACCT_ENTRY) acct <= ent_shl;
                  else                     pswd <= ent_shl;
                  cnt <= cnt + ONE;
                  if (cnt == LAST) begin
                     status_code  <= ST_INPUT_DONE;
                     status_valid <= 1'b1;
                  end
               end else if (is_bs && (cnt != '0)) begin
                  if (state == ACCT_ENTRY) acct <= ent_shr;
                  else                     pswd <= ent_shr;
                  cnt <= cnt - ONE;
               end else if (is_enter && (cnt == FULL)) begin
                  state <= (state == ACCT_ENTRY) ? ACCT_CHECK : PIN_CHECK;
               end
            end
            ACCT_CHECK: begin
               status_valid <= 1'b1;
               cnt          <= '0;
               if (acct_hit) begin
                  acct_idx    <= hit_idx;
                  status_code <= ST_ACC_FOUND;
                  state       <= PIN_ENTRY;
               end else begin
                  acct        <= '0;
                  status_code <= ST_ACC_NOT_FOUND;
                  state       <= ACCT_ENTRY;
               end
            end
            PIN_CHECK: begin
               status_valid <= 1'b1;
               if (pswd == pin_sel) begin
                  status_code <= ST_PIN_CORRECT;
                  state       <= DONE;
               end else begin
                  status_code <= ST_PIN_INCORRECT;
                  tries       <= tries_nx;
                  pswd        <= '0;
                  cnt         <= '0;
                  state       <= (tries_nx == TRY_LIM) ? LOCKED : PIN_ENTRY;
               end
            end
            DONE: begin
               if (is_quit) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  tries        <= '0;
                  acct         <= '0;
                  pswd         <= '0;
                  acct_idx     <= '0;
                  status_code  <= ST_EXIT;
                  status_valid <= 1'b1;
               end
            end
            LOCKED: begin
               // Only rst_n leaves this state.
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/atm_credential_entry.md
ATM_CREDENTIAL_ENTRY -- requirements
Module: atm_credential_entry

Interface
REQ-001 Parameter DIGITS, default 4, digits per account number and per PIN (2..8).
REQ-002 Parameter NUM_ACCTS, default 3, number of account/PIN table entries (1..16).
REQ-003 Parameter MAX_TRIES, default 3, wrong-PIN attempts before lockout (1..7).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse beginning a session; honoured only in IDLE.
REQ-007 key_valid  input  1  qualifies ascii_code for exactly one cycle per keypress.
REQ-008 ascii_code  input  8  key code: 0x30-0x39 digit, 0x08 backspace, 0x0D enter, 0x71 'q' exit.
REQ-009 acct_table  input  NUM_ACCTS*4*DIGITS  packed BCD accounts, entry i at bits [i*4*DIGITS +: 4*DIGITS].
REQ-010 pin_table  input  NUM_ACCTS*4*DIGITS  packed BCD PINs, same layout as acct_table.
REQ-011 acct  output  4*DIGITS  account digit buffer, first-entered digit in most-significant nibble.
REQ-012 pswd  output  4*DIGITS  PIN digit buffer, same ordering.
REQ-013 acct_idx  output  4  index of matched account; valid from ACC_FOUND until IDLE.
REQ-014 status_code  output  4  last event: 0001 ACC_FOUND, 0010 ACC_NOT_FOUND, 0011 PIN_CORRECT, 0100 PIN_INCORRECT, 0111 EXIT, 1000 INPUT_COMPLETE.
REQ-015 status_valid  output  1  one-cycle pulse marking a new status_code.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 locked  output  1  high in LOCKED.

Function
REQ-018 FSM states SHALL be IDLE, ACCT_ENTRY, ACCT_CHECK, PIN_ENTRY, PIN_CHECK, DONE, LOCKED.
REQ-019 IDLE + start -> ACCT_ENTRY next cycle; digit counter, try counter, acct, pswd cleared.
REQ-020 A key is accepted only when key_valid=1 in an ENTRY state; response is registered, visible next cycle.
REQ-021 Digit with count<DIGITS: buffer <= {buffer[4*DIGITS-5:0], ascii_code[3:0]}, count+1; digits at count=DIGITS are ignored.
REQ-022 The digit that makes count=DIGITS SHALL also pulse status INPUT_COMPLETE.
REQ-023 Backspace with count>0: buffer shifts right one nibble (zero fill at top), count-1; at count=0 ignored.
REQ-024 Enter with count=DIGITS -> CHECK state; enter with count<DIGITS ignored, no status.
REQ-025 Codes other than digit/backspace/enter/'q' SHALL be ignored.
REQ-026 ACCT_CHECK, one cycle: compare acct with all entries; lowest matching index -> acct_idx, ACC_FOUND, PIN_ENTRY, count cleared.
REQ-027 ACCT_CHECK with no match: ACC_NOT_FOUND, acct and count cleared, back to ACCT_ENTRY.
REQ-028 PIN_CHECK, one cycle: pswd equal to entry acct_idx -> PIN_CORRECT, DONE; acct and pswd held.
REQ-029 PIN_CHECK mismatch: PIN_INCORRECT, try counter+1, pswd and count cleared; next state LOCKED if new count = MAX_TRIES, else PIN_ENTRY.
REQ-030 Latency: enter accepted at edge t -> CHECK state after t -> status_valid high for the cycle after edge t+1.
REQ-031 'q' in ACCT_ENTRY, PIN_ENTRY or DONE: EXIT pulse, all buffers/counters cleared, IDLE; 'q' ignored in IDLE, CHECK states, LOCKED.
REQ-032 key_valid during CHECK states SHALL be dropped, not queued; start outside IDLE ignored.
REQ-033 LOCKED SHALL ignore all inputs; exit only via rst_n.
REQ-034 status_code holds its value between pulses; status_valid never high two consecutive cycles except when two events occur on consecutive cycles.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, acct=0, pswd=0, acct_idx=0, status_code=0000, status_valid=0, busy=0, locked=0, counters=0, including mid-entry or mid-check.
REQ-036 First state change after rst_n release occurs on the first rising clk edge with rst_n=1.

Verification
REQ-037 DIGITS=4, acct_table entry1=0x1111; start, keys '1','1','1','1',enter -> INPUT_COMPLETE on 4th digit, then ACC_FOUND, acct_idx=1, acct=0x1111.
REQ-038 Keys '1','2',backspace,'3','4','5',enter -> acct=0x1345; enter after 3 digits -> no status.
REQ-039 Account 0x9999 not in table -> ACC_NOT_FOUND, acct=0, state ACCT_ENTRY.
REQ-040 Valid account, PIN wrong three times (MAX_TRIES=3) -> three PIN_INCORRECT pulses, locked=1; further keys no response.
REQ-041 'q' after two PIN digits -> EXIT pulse, busy=0, pswd=0.
REQ-042 rst_n asserted during PIN_CHECK cycle -> no status pulse, all outputs at reset values same cycle.
